// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package reg_writeback_arbiter_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // Byte-lane select followed by sign/zero extension; misaligned offsets
  // simply take whatever the shift leaves in the low bits.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                  input logic [2:0]      off,
                                                  input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] res;
    lane = raw >> {off, 3'b000};
    case (f3)
      F3_LB:   res = {{56{lane[7]}}, lane[7:0]};
      F3_LH:   res = {{48{lane[15]}}, lane[15:0]};
      F3_LW:   res = {{32{lane[31]}}, lane[31:0]};
      F3_LD:   res = raw;
      F3_LBU:  res = {56'd0, lane[7:0]};
      F3_LHU:  res = {48'd0, lane[15:0]};
      F3_LWU:  res = {32'd0, lane[31:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// ALU / load / writeback bundle between the arbiter and its neighbours.
interface reg_writeback_arbiter_if
  import reg_writeback_arbiter_pkg::*;
  #(parameter int LQ_DEPTH = 4);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [2:0]            mem_funct3;
  logic [2:0]            mem_addr_lo;
  logic [XLEN-1:0]       mem_rdata;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic [CNT_W-1:0]      lq_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_funct3, mem_addr_lo, mem_rdata,
    input  alu_ready, mem_ready, wb_reg_write, wb_rd, wb_data, lq_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_funct3, mem_addr_lo, mem_rdata,
    output alu_ready, mem_ready, wb_reg_write, wb_rd, wb_data, lq_count
  );

endinterface

// File: rtl/reg_writeback_arbiter_fifo.sv
// Synchronous load FIFO holding already-extended {rd, data} entries.
module reg_writeback_arbiter_fifo
  import reg_writeback_arbiter_pkg::*;
  #(parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH))
  (input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  wb_entry_t        i_din,
   output wb_entry_t        o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_reset) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU results and extended load completions onto the single
// register-file write port, with a forced load drain after sustained ALU traffic.
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
  #(parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8)
  (input logic                     i_clk,
   input logic                     i_reset,
   reg_writeback_arbiter_if.slave  io_bus);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             w_push_entry;
  wb_entry_t             w_head;
  wb_entry_t             w_grant_entry;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic                  w_force;
  logic                  w_alu_ready;
  logic                  w_alu_win;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_grant;
  logic [ST_W-1:0]       r_starve;
  logic                  r_wb_we;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [XLEN-1:0]       r_wb_data;

  assign w_push_entry = '{rd:   io_bus.mem_rd,
                          data: load_extend(io_bus.mem_funct3, io_bus.mem_addr_lo, io_bus.mem_rdata)};

  assign w_force     = (r_starve == ST_W'(STARVE_LIMIT)) & ~w_empty;
  assign w_alu_ready = ~i_reset & ~w_force;
  assign w_alu_win   = io_bus.alu_valid & w_alu_ready;
  assign w_pop       = ~i_reset & ~w_alu_win & ~w_empty;
  assign w_push      = io_bus.mem_valid & io_bus.mem_ready;
  assign w_grant     = w_alu_win | w_pop;

  assign w_grant_entry = w_alu_win ? wb_entry_t'{rd: io_bus.alu_rd, data: io_bus.alu_data} : w_head;

  assign io_bus.alu_ready    = w_alu_ready;
  assign io_bus.mem_ready    = ~i_reset & ~w_full;
  assign io_bus.wb_reg_write = r_wb_we;
  assign io_bus.wb_rd        = r_wb_rd;
  assign io_bus.wb_data      = r_wb_data;
  assign io_bus.lq_count     = w_count;

  reg_writeback_arbiter_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_entry),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Count ALU wins that bypass waiting loads; any drain or empty queue restarts it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (w_pop || w_empty) begin
      r_starve <= '0;
    end else if (w_alu_win && (r_starve != ST_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Register the granted result; x0 targets are consumed without a write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_we <= w_grant && (w_grant_entry.rd != '0);
      if (w_grant && (w_grant_entry.rd != '0)) begin
        r_wb_rd   <= w_grant_entry.rd;
        r_wb_data <= w_grant_entry.data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;
  import reg_writeback_arbiter_pkg::*;

  localparam int LQ_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  reg_writeback_arbiter_if #(.LQ_DEPTH(LQ_DEPTH)) bus ();

  reg_writeback_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  wb_entry_t   mq[$];
  int          m_starve;
  logic        exp_we, exp_alu_ready, exp_mem_ready;
  logic [4:0]  exp_rd;
  logic [63:0] exp_data;
  logic        obs_alu_ready, obs_mem_ready;

  function automatic logic [63:0] ref_ext(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] raw);
    logic [63:0] lane, v;
    lane = raw >> (8 * off);
    case (f3)
      3'd0: begin v = lane % 64'd256;        if (v >= 64'd128)        v = v - 64'd256;        end
      3'd1: begin v = lane % 64'd65536;      if (v >= 64'd32768)      v = v - 64'd65536;      end
      3'd2: begin v = lane % 64'h1_0000_0000; if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000; end
      3'd3: v = raw;
      3'd4: v = lane % 64'd256;
      3'd5: v = lane % 64'd65536;
      3'd6: v = lane % 64'h1_0000_0000;
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  // One clock: sample readies mid-cycle, advance the model, return #1 after the edge.
  task automatic tick();
    wb_entry_t g;
    logic win, granted, was_empty;
    @(negedge clk);
    obs_alu_ready = bus.alu_ready;
    obs_mem_ready = bus.mem_ready;
    if (rst) begin
      exp_alu_ready = 1'b0; exp_mem_ready = 1'b0;
      mq.delete(); m_starve = 0;
      exp_we = 1'b0; exp_rd = '0; exp_data = '0;
    end else begin
      was_empty     = (mq.size() == 0);
      exp_alu_ready = !((m_starve == STARVE_LIMIT) && !was_empty);
      exp_mem_ready = (mq.size() < LQ_DEPTH);
      win           = bus.alu_valid && exp_alu_ready;
      granted       = win || !was_empty;
      g             = '0;
      if (win) g = '{rd: bus.alu_rd, data: bus.alu_data};
      else if (!was_empty) g = mq.pop_front();
      if (bus.mem_valid && exp_mem_ready)
        mq.push_back('{rd: bus.mem_rd, data: ref_ext(bus.mem_funct3, bus.mem_addr_lo, bus.mem_rdata)});
      if (!win || was_empty) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      exp_we = granted && (g.rd != 0);
      if (exp_we) begin exp_rd = g.rd; exp_data = g.data; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs_alu_ready !== 1'b0 || obs_mem_ready !== 1'b0)
        $display("FAIL reset_ready cyc %0d: got alu=%b mem=%b want 0 0", i, obs_alu_ready, obs_mem_ready);
      else n_pass++;
      n_checks++;
      if (bus.wb_reg_write !== 1'b0 || bus.lq_count !== 3'd0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 64'd0)
        $display("FAIL reset_out cyc %0d: got we=%b cnt=%0d rd=%0d data=%h want 0", i, bus.wb_reg_write, bus.lq_count, bus.wb_rd, bus.wb_data);
      else n_pass++;
    end
    rst = 1'b0;
    n_checks++;
    if (bus.wb_reg_write !== 1'b0) $display("FAIL reset_release_we: got %b want 0", bus.wb_reg_write);
    else n_pass++;
    tick();
    n_checks++;
    if (obs_alu_ready !== 1'b1 || obs_mem_ready !== 1'b1)
      $display("FAIL release_ready: got alu=%b mem=%b want 1 1", obs_alu_ready, obs_mem_ready);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h2A;
    tick();
    n_checks++;
    if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 64'h2A)
      $display("FAIL alu_write: got we=%b rd=%0d data=%h want 1 5 2a", bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    else n_pass++;
    bus.alu_rd = 5'd0; bus.alu_data = 64'h77;
    tick();
    n_checks++;
    if (bus.wb_reg_write !== 1'b0 || bus.wb_rd !== 5'd5 || bus.wb_data !== 64'h2A)
      $display("FAIL alu_rd0: got we=%b rd=%0d data=%h want 0 5 2a", bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_extension();
    logic [2:0]  f3  [9];
    logic [2:0]  off [9];
    logic [63:0] want[9];
    f3[0] = 3'b000; off[0] = 3'd0; want[0] = 64'hFFFF_FFFF_FFFF_FF80;
    f3[1] = 3'b100; off[1] = 3'd0; want[1] = 64'h80;
    f3[2] = 3'b001; off[2] = 3'd2; want[2] = 64'h00F0;
    f3[3] = 3'b010; off[3] = 3'd4; want[3] = 64'hFFFF_FFFF_8000_0000;
    f3[4] = 3'b011; off[4] = 3'd5; want[4] = 64'h8000_0000_00F0_FF80;
    f3[5] = 3'b101; off[5] = 3'd0; want[5] = 64'hFF80;
    f3[6] = 3'b110; off[6] = 3'd0; want[6] = 64'h00F0_FF80;
    f3[7] = 3'b111; off[7] = 3'd0; want[7] = 64'd0;
    f3[8] = 3'b000; off[8] = 3'd1; want[8] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b1; bus.mem_rd = 5'(10 + i);
      bus.mem_funct3 = f3[i]; bus.mem_addr_lo = off[i]; bus.mem_rdata = 64'h8000_0000_00F0_FF80;
      tick();
      bus.mem_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 5'(10 + i) || bus.wb_data !== want[i])
        $display("FAIL ext_%0d: got we=%b rd=%0d data=%h want 1 %0d %h", i, bus.wb_reg_write, bus.wb_rd, bus.wb_data, 10 + i, want[i]);
      else n_pass++;
    end
    idle(2);
  endtask

  task automatic test_starvation();
    int pushes, first_full, first_low, double_low;
    logic prev_low, low;
    logic [4:0] order[$];
    pushes = 0; first_full = -1; first_low = -1; double_low = 0; prev_low = 1'b0;
    bus.alu_valid = 1'b1; bus.mem_valid = 1'b1; bus.mem_funct3 = 3'b011; bus.mem_addr_lo = 3'd0;
    for (int c = 0; c < 70; c++) begin
      bus.alu_rd = 5'($urandom_range(1, 19)); bus.alu_data = {$urandom, $urandom};
      bus.mem_rd = 5'(20 + pushes); bus.mem_rdata = {$urandom, $urandom};
      if (pushes >= 5) bus.mem_valid = 1'b0;
      if (c == 60) bus.alu_valid = 1'b0;
      tick();
      if (bus.mem_valid && obs_mem_ready) pushes++;
      if (!obs_mem_ready && first_full < 0) first_full = pushes;
      low = bus.alu_valid && !obs_alu_ready;
      if (low && first_low < 0) first_low = c;
      if (low && prev_low) double_low++;
      prev_low = low;
      if (bus.wb_reg_write && bus.wb_rd >= 5'd20) order.push_back(bus.wb_rd);
      n_checks++;
      if ({obs_alu_ready, obs_mem_ready, bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.lq_count} !==
          {exp_alu_ready, exp_mem_ready, exp_we, exp_rd, exp_data, 3'(mq.size())})
        $display("FAIL starve_cyc %0d: got ar=%b mr=%b we=%b rd=%0d data=%h cnt=%0d want ar=%b mr=%b we=%b rd=%0d data=%h cnt=%0d",
                 c, obs_alu_ready, obs_mem_ready, bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.lq_count,
                 exp_alu_ready, exp_mem_ready, exp_we, exp_rd, exp_data, mq.size());
      else n_pass++;
    end
    n_checks++;
    if (first_full != LQ_DEPTH) $display("FAIL starve_full_after: got %0d pushes want %0d", first_full, LQ_DEPTH);
    else n_pass++;
    n_checks++;
    if (first_low != STARVE_LIMIT + 1) $display("FAIL starve_first_force: got cycle %0d want %0d", first_low, STARVE_LIMIT + 1);
    else n_pass++;
    n_checks++;
    if (double_low != 0) $display("FAIL starve_pulse_width: got %0d double-low cycles want 0", double_low);
    else n_pass++;
    n_checks++;
    if (order.size() != 5) $display("FAIL starve_load_count: got %0d want 5", order.size());
    else n_pass++;
    for (int i = 0; i < order.size(); i++) begin
      n_checks++;
      if (order[i] !== 5'(20 + i)) $display("FAIL starve_order %0d: got rd=%0d want %0d", i, order[i], 20 + i);
      else n_pass++;
    end
    idle(2);
  endtask

  task automatic test_wrap();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.mem_valid = 1'b1;
    bus.mem_funct3 = 3'b011; bus.mem_addr_lo = 3'd0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_rd = 5'(8 + i); bus.mem_rdata = {$urandom, $urandom};
      tick();
    end
    n_checks++;
    if (bus.lq_count !== 3'd2) $display("FAIL wrap_fill: got cnt=%0d want 2", bus.lq_count);
    else n_pass++;
    bus.alu_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.mem_rd = 5'(10 + k); bus.mem_rdata = {$urandom, $urandom};
      tick();
      n_checks++;
      if (bus.lq_count !== 3'd2 || bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 5'(8 + k) || bus.wb_data !== exp_data)
        $display("FAIL wrap_%0d: got cnt=%0d we=%b rd=%0d data=%h want 2 1 %0d %h", k, bus.lq_count, bus.wb_reg_write, bus.wb_rd, bus.wb_data, 8 + k, exp_data);
      else n_pass++;
    end
    idle(3);
    n_checks++;
    if (bus.lq_count !== 3'd0 || bus.wb_rd !== 5'd19) $display("FAIL wrap_drain: got cnt=%0d rd=%0d want 0 19", bus.lq_count, bus.wb_rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rd = 5'(1 + i); bus.mem_rdata = {$urandom, $urandom};
      tick();
    end
    n_checks++;
    if (bus.lq_count !== 3'd3) $display("FAIL rstmid_fill: got cnt=%0d want 3", bus.lq_count);
    else n_pass++;
    rst = 1'b1; bus.alu_rd = 5'd7;
    tick(); tick();
    rst = 1'b0; bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    n_checks++;
    if (bus.lq_count !== 3'd0 || bus.wb_reg_write !== 1'b0)
      $display("FAIL rstmid_release: got cnt=%0d we=%b want 0 0", bus.lq_count, bus.wb_reg_write);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.lq_count !== 3'd0 || bus.wb_reg_write !== 1'b0)
        $display("FAIL rstmid_stale %0d: got cnt=%0d we=%b want 0 0", i, bus.lq_count, bus.wb_reg_write);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst             = ($urandom_range(0, 49) == 0);
      bus.alu_valid   = $urandom_range(0, 1) == 1;
      bus.alu_rd      = 5'($urandom_range(0, 31));
      bus.alu_data    = {$urandom, $urandom};
      bus.mem_valid   = $urandom_range(0, 9) < 6;
      bus.mem_rd      = 5'($urandom_range(0, 31));
      bus.mem_funct3  = 3'($urandom_range(0, 7));
      bus.mem_addr_lo = 3'($urandom_range(0, 7));
      bus.mem_rdata   = {$urandom, $urandom};
      tick();
      n_checks++;
      if ({obs_alu_ready, obs_mem_ready, bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.lq_count} !==
          {exp_alu_ready, exp_mem_ready, exp_we, exp_rd, exp_data, 3'(mq.size())})
        $display("FAIL random_cyc %0d: got ar=%b mr=%b we=%b rd=%0d data=%h cnt=%0d want ar=%b mr=%b we=%b rd=%0d data=%h cnt=%0d",
                 c, obs_alu_ready, obs_mem_ready, bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.lq_count,
                 exp_alu_ready, exp_mem_ready, exp_we, exp_rd, exp_data, mq.size());
      else n_pass++;
    end
    rst = 1'b0;
    idle(6);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_starve = 0;
    exp_we = 1'b0; exp_rd = '0; exp_data = '0;
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_funct3 = '0; bus.mem_addr_lo = '0; bus.mem_rdata = '0;
    test_reset();
    test_alu();
    test_extension();
    test_starvation();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
